reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined core: XLEN x NREGS, NRD read ports, two write ports.
//  Adds optional write-to-read bypass, register 0 hardwired to zero, a per-register pending scoreboard
//  and a sequential clear sweep. Sits between decode (reads/reserve) and writeback (two retire lanes).
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of registers (power of 2, >=4); AW = $clog2(NREGS)
//  NRD      2   number of read ports (1..4)
//  ZERO_REG 1   1: register 0 reads 0, is never written and never pending
//  BYPASS   1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  we0        in   1         write enable, lane 0
//  waddr0     in   AW        write address, lane 0
//  wdata0     in   XLEN      write data, lane 0
//  we1        in   1         write enable, lane 1 (priority lane)
//  waddr1     in   AW        write address, lane 1
//  wdata1     in   XLEN      write data, lane 1
//  raddr      in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rdata      out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN], combinational
//  rbusy      out  NRD       port i address has a pending (unwritten) producer
//  rsv_valid  in   1         reserve: mark rsv_addr pending
//  rsv_addr   in   AW        register to reserve
//  clear_req  in   1         pulse: start sweep zeroing every register
//  clear_busy out  1         sweep in progress
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all pending bits 0, FSM IDLE, clear_busy=0.
//  - Writes: registered on posedge clk; visible on rdata the next cycle (without bypass).
//  - we0 & we1 to same address: lane 1 data written, lane 0 discarded.
//  - ZERO_REG=1: writes/reserves to address 0 ignored; rdata for address 0 = 0; rbusy = 0.
//  - Read: rdata[i] = array[raddr[i]], zero-latency. BYPASS=1: if we1 & waddr1==raddr[i] -> wdata1,
//    else if we0 & waddr0==raddr[i] -> wdata0, else array. Address 0 still reads 0.
//  - Scoreboard: pending[a] set on posedge when rsv_valid & rsv_addr==a; cleared when a write
//    (either lane) hits a. Set and clear same cycle, same address: set wins (new producer).
//  - rbusy[i] = pending[raddr[i]]; BYPASS=1 additionally masks it to 0 when a write to raddr[i]
//    is present this cycle.
//  - Clear FSM: IDLE --clear_req--> SWEEP; SWEEP zeroes register cnt and clears pending[cnt] each
//    cycle, cnt 0..NREGS-1, returns to IDLE after NREGS cycles. clear_busy=1 exactly in SWEEP.
//  - During SWEEP: we0/we1 and rsv_valid ignored (dropped); reads return current array contents,
//    bypass disabled; clear_req ignored (no restart).
//  - Reset mid-sweep: immediate return to IDLE with everything zero.
//  - cnt width AW+1 so terminal compare does not wrap.
// STRUCTURE
//  - Shared package reg_file_pkg: clear FSM state enum (IDLE, SWEEP), default XLEN/NREGS constants.
//  - One sub-module: rf_read_port (one combinational read mux + bypass + rbusy), instantiated NRD
//    times by generate; array, scoreboard and clear FSM stay in the top.
// TESTING
//  1. Reset, then read all 32 addrs -> rdata=0, rbusy=0, clear_busy=0.
//  2. we0 a=5 d=0xDEADBEEF; next cycle raddr0=5 -> 0xDEADBEEF; write a=0 d=1 -> reads 0.
//  3. we0 a=7 d=0x11 & we1 a=7 d=0x22 same cycle -> reg7=0x22; BYPASS: same cycle raddr1=7 -> 0x22.
//  4. rsv a=9 -> rbusy=1 next cycle; write a=9 -> rbusy=0 in that cycle (bypass), stays 0 after;
//     rsv a=9 with write a=9 same cycle -> pending stays 1.
//  5. fill regs, clear_req -> clear_busy high exactly 32 cycles, write during sweep dropped, all 0 after.
//  6. assert rst_n=0 at sweep cycle 10 -> clear_busy=0 at once, all regs 0; repeat with NRD=3, NREGS=16.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types for the multi-port register file.
// Clear-sweep FSM states and default geometry.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    IDLE,
    SWEEP
  } clr_state_t;

endpackage

// File: rtl/reg_file_mp_read.sv
// One combinational read port: array mux result,
// same-cycle write forwarding and busy masking.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] rval,
  input  logic            pend,
  input  logic            wr0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wr1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] rdata,
  output logic            rbusy
);

  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = ZERO_REG && (raddr == '0);
  assign hit0    = BYPASS && wr0 && (waddr0 == raddr);
  assign hit1    = BYPASS && wr1 && (waddr1 == raddr);

  // Lane 1 outranks lane 0, mirroring the array write.
  always_comb begin
    rdata = rval;
    rbusy = pend;
    if (is_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (hit1) begin
      rdata = wdata1;
      rbusy = 1'b0;
    end else if (hit0) begin
      rdata = wdata0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write lanes, NRD reads,
// pending scoreboard and a one-register-per-cycle clear sweep.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [XLEN-1:0]   wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [XLEN-1:0]   wdata1,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              clear_req,
  output logic              clear_busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_nx;
  clr_state_t       state;
  clr_state_t       state_nx;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nx;
  logic             sweep;
  logic             wr0;
  logic             wr1;
  logic             rsv;
  logic [AW-1:0]    sw_idx;

  assign sweep  = (state == SWEEP);
  assign sw_idx = cnt[AW-1:0];
  assign clear_busy = sweep;

  // Effective requests: dropped while sweeping, never hit reg 0.
  assign wr0 = we0 && !sweep &&
               !(ZERO_REG && (waddr0 == '0));
  assign wr1 = we1 && !sweep &&
               !(ZERO_REG && (waddr1 == '0));
  assign rsv = rsv_valid && !sweep &&
               !(ZERO_REG && (rsv_addr == '0));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end
      end
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt_nx == (AW+1)'(NREGS)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (sweep) begin
      regs[sw_idx] <= '0;
    end else begin
      if (wr0) regs[waddr0] <= wdata0;
      if (wr1) regs[waddr1] <= wdata1;
    end
  end

  // A reserve lands after the clears: a new producer wins.
  always_comb begin
    pend_nx = pending;
    if (sweep) begin
      pend_nx[sw_idx] = 1'b0;
    end else begin
      if (wr0) pend_nx[waddr0] = 1'b0;
      if (wr1) pend_nx[waddr1] = 1'b0;
      if (rsv) pend_nx[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nx;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    rf_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .raddr  (ra),
      .rval   (regs[ra]),
      .pend   (pending[ra]),
      .wr0    (wr0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .wr1    (wr1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .rdata  (rdata[i*XLEN +: XLEN]),
      .rbusy  (rbusy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a 32x2 and a 16x3 instance share
// stimulus and are checked against an array-based model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we0, we1, rsv_valid, clear_req;
  logic [4:0]  waddr0, waddr1, rsv_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr_a;
  logic [11:0] raddr_b;
  logic [63:0] rdata_a;
  logic [95:0] rdata_b;
  logic [1:0]  rbusy_a;
  logic [2:0]  rbusy_b;
  logic        cb_a, cb_b;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [16];
  bit          pa [32];
  bit          pb [16];
  int          swa, swb;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .clear_req(clear_req), .clear_busy(cb_a)
  );

  reg_file_mp #(.XLEN(32), .NREGS(16), .NRD(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0[3:0]), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1[3:0]), .wdata1(wdata1),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr[3:0]),
    .clear_req(clear_req), .clear_busy(cb_b)
  );

  task automatic expect_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin ma[i] = '0; pa[i] = 0; end
    for (int i = 0; i < 16; i++) begin mb[i] = '0; pb[i] = 0; end
    swa = 0;
    swb = 0;
  endfunction

  function automatic void mset(input int m, input int a,
                               input logic [31:0] d, input bit p);
    if (m != 0) begin mb[a] = d; pb[a] = p; end
    else        begin ma[a] = d; pa[a] = p; end
  endfunction

  function automatic void pset(input int m, input int a, input bit p);
    if (m != 0) pb[a] = p;
    else        pa[a] = p;
  endfunction

  // Expected combinational read for model m at register r.
  function automatic void exp_port(input int m, input int r,
                                   output logic [31:0] d,
                                   output bit b);
    int msk = (m != 0) ? 15 : 31;
    int sw  = (m != 0) ? swb : swa;
    int a0  = int'(waddr0) & msk;
    int a1  = int'(waddr1) & msk;
    d = (m != 0) ? mb[r] : ma[r];
    b = (m != 0) ? pb[r] : pa[r];
    if (r == 0) begin
      d = '0; b = 0;
    end else if (sw == 0 && we1 && a1 == r) begin
      d = wdata1; b = 0;
    end else if (sw == 0 && we0 && a0 == r) begin
      d = wdata0; b = 0;
    end
  endfunction

  function automatic void upd(input int m);
    int n   = (m != 0) ? 16 : 32;
    int msk = n - 1;
    int a0  = int'(waddr0) & msk;
    int a1  = int'(waddr1) & msk;
    int ar  = int'(rsv_addr) & msk;
    int sw  = (m != 0) ? swb : swa;
    if (sw > 0) begin
      mset(m, n - sw, '0, 0);
      sw--;
    end else begin
      if (we0 && a0 != 0) mset(m, a0, wdata0, 0);
      if (we1 && a1 != 0) mset(m, a1, wdata1, 0);
      if (rsv_valid && ar != 0) pset(m, ar, 1);
      if (clear_req) sw = n;
    end
    if (m != 0) swb = sw;
    else        swa = sw;
  endfunction

  task automatic check_all();
    logic [31:0] d;
    bit b;
    for (int i = 0; i < 2; i++) begin
      exp_port(0, int'(raddr_a[i*5 +: 5]), d, b);
      expect_eq($sformatf("a.rdata%0d", i), 64'(rdata_a[i*32 +: 32]), 64'(d));
      expect_eq($sformatf("a.rbusy%0d", i), 64'(rbusy_a[i]), 64'(b));
    end
    for (int i = 0; i < 3; i++) begin
      exp_port(1, int'(raddr_b[i*4 +: 4]), d, b);
      expect_eq($sformatf("b.rdata%0d", i), 64'(rdata_b[i*32 +: 32]), 64'(d));
      expect_eq($sformatf("b.rbusy%0d", i), 64'(rbusy_b[i]), 64'(b));
    end
    expect_eq("a.clear_busy", 64'(cb_a), 64'(swa > 0));
    expect_eq("b.clear_busy", 64'(cb_b), 64'(swb > 0));
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic tick();
    #2 check_all();
    @(posedge clk);
    upd(0);
    upd(1);
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_valid = 0; clear_req = 0;
    waddr0 = '0; waddr1 = '0; rsv_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr_a = {5'(a), 5'(31 - a)};
      raddr_b = {4'(a), 4'(a + 5), 4'(15 - a)};
      tick();
    end
  endtask

  initial begin
    int n_a, n_b;
    idle();
    raddr_a = '0;
    raddr_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    read_all();

    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    idle();
    raddr_a = {5'd0, 5'd5};
    #1 expect_eq("t2.r5", 64'(rdata_a[31:0]), 64'h00000000DEADBEEF);
    tick();
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'h1;
    raddr_a = {5'd0, 5'd0};
    tick();
    idle();
    #1 expect_eq("t2.r0", 64'(rdata_a[31:0]), 64'h0);
    tick();

    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
    raddr_a = {5'd7, 5'd0};
    #1 expect_eq("t3.byp", 64'(rdata_a[63:32]), 64'h22);
    tick();
    idle();
    #1 expect_eq("t3.r7", 64'(rdata_a[63:32]), 64'h22);
    tick();

    rsv_valid = 1; rsv_addr = 5'd9;
    tick();
    idle();
    raddr_a = {5'd9, 5'd9};
    #1 expect_eq("t4.busy", 64'(rbusy_a), 64'h3);
    tick();
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h99;
    #1 expect_eq("t4.mask", 64'(rbusy_a), 64'h0);
    tick();
    idle();
    #1 expect_eq("t4.after", 64'(rbusy_a), 64'h0);
    tick();
    rsv_valid = 1; rsv_addr = 5'd9;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h77;
    tick();
    idle();
    #1 expect_eq("t4.setwins", 64'(rbusy_a), 64'h3);
    tick();

    for (int a = 1; a < 32; a++) begin
      we0 = 1; waddr0 = 5'(a); wdata0 = $urandom;
      tick();
    end
    idle();
    clear_req = 1;
    tick();
    clear_req = 0;
    n_a = 0;
    n_b = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'h55;
        rsv_valid = 1; rsv_addr = 5'd4;
        clear_req = 1;
      end else begin
        idle();
      end
      #1;
      if (cb_a) n_a++;
      if (cb_b) n_b++;
      tick();
    end
    expect_eq("t5.len_a", 64'(n_a), 64'd32);
    expect_eq("t5.len_b", 64'(n_b), 64'd16);
    raddr_a = {5'd4, 5'd4};
    #1 expect_eq("t5.drop", 64'(rdata_a), 64'h0);
    read_all();

    for (int a = 1; a < 32; a++) begin
      we1 = 1; waddr1 = 5'(a); wdata1 = $urandom | 32'h1;
      rsv_valid = 1; rsv_addr = 5'(a + 3);
      tick();
    end
    idle();
    clear_req = 1;
    tick();
    idle();
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    expect_eq("t6.busy_a", 64'(cb_a), 64'h0);
    expect_eq("t6.busy_b", 64'(cb_b), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    read_all();

    repeat (600) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      waddr0 = 5'($urandom);
      waddr1 = 5'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom);
      clear_req = ($urandom_range(0, 79) == 0);
      raddr_a = 10'($urandom);
      raddr_b = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        raddr_a[4:0] = waddr1;
        raddr_b[3:0] = waddr0[3:0];
        raddr_b[7:4] = rsv_addr[3:0];
      end
      tick();
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
